// File: rtl/issue_queue16_if.sv
// Issue queue bus interface: instruction insert, tag wakeup, arbiter
// request/grant, and the registered issue output.
//   master : producer/arbiter side (drives alloc_*, wakeup_*, granted)
//   slave  : queue side (drives alloc_ready, ready, issue_*, count)
interface issue_queue16_if;
  logic        alloc_valid;
  logic [5:0]  alloc_src1;
  logic [5:0]  alloc_src2;
  logic        alloc_src1_rdy;
  logic        alloc_src2_rdy;
  logic [5:0]  alloc_dest;
  logic [31:0] alloc_payload;
  logic        alloc_ready;
  logic        wakeup_valid;
  logic [5:0]  wakeup_tag;
  logic [15:0] ready;
  logic [4:0]  granted;
  logic        issue_valid;
  logic [3:0]  issue_index;
  logic [5:0]  issue_dest;
  logic [31:0] issue_payload;
  logic [4:0]  count;

  modport master (
    output alloc_valid, alloc_src1, alloc_src2, alloc_src1_rdy, alloc_src2_rdy,
           alloc_dest, alloc_payload, wakeup_valid, wakeup_tag, granted,
    input  alloc_ready, ready, issue_valid, issue_index, issue_dest,
           issue_payload, count
  );

  modport slave (
    input  alloc_valid, alloc_src1, alloc_src2, alloc_src1_rdy, alloc_src2_rdy,
           alloc_dest, alloc_payload, wakeup_valid, wakeup_tag, granted,
    output alloc_ready, ready, issue_valid, issue_index, issue_dest,
           issue_payload, count
  );
endinterface

// File: rtl/issue_queue16.sv
// 16-entry out-of-order issue queue with tag wakeup and one issue per cycle.
// Ports:
//   CLK   - clock, all state updates on the rising edge
//   RESET - synchronous active-high reset, highest priority
//   FLUSH - discards all entries at the next edge
//   bus   - issue_queue16_if.slave (insert, wakeup, request/grant, issue, count)
// Build option: define IQ_FAST_WAKEUP_EN to let a same-cycle wakeup tag
// bypass into the ready request vector; otherwise ready uses stored bits only.
module issue_queue16 (
  input logic             CLK,
  input logic             RESET,
  input logic             FLUSH,
  issue_queue16_if.slave  bus
);
  localparam int unsigned N  = 16;
  localparam int unsigned TW = 6;
  localparam int unsigned PW = 32;
  localparam int unsigned IW = 4;
  localparam int unsigned CW = 5;

  logic [N-1:0]  valid_q;
  logic [N-1:0]  s1_rdy_q;
  logic [N-1:0]  s2_rdy_q;
  logic [TW-1:0] s1_tag_q  [N];
  logic [TW-1:0] s2_tag_q  [N];
  logic [TW-1:0] dest_q    [N];
  logic [PW-1:0] payload_q [N];
  logic [CW-1:0] count_q;

  logic          issue_valid_q;
  logic [IW-1:0] issue_index_q;
  logic [TW-1:0] issue_dest_q;
  logic [PW-1:0] issue_payload_q;

  logic [N-1:0]  s1_eff;
  logic [N-1:0]  s2_eff;
  logic [N-1:0]  ready_c;
  logic          free_found;
  logic [IW-1:0] free_idx;
  logic          alloc_ready_c;
  logic          do_alloc;
  logic [IW-1:0] grant_idx;
  logic          do_issue;
  logic          alloc_s1_rdy;
  logic          alloc_s2_rdy;

  // Per-slot source readiness feeding the arbiter request vector
  always_comb begin
    s1_eff = '0;
    s2_eff = '0;
    for (int i = 0; i < N; i++) begin
`ifdef IQ_FAST_WAKEUP_EN
      s1_eff[i] = s1_rdy_q[i] | (bus.wakeup_valid && (s1_tag_q[i] == bus.wakeup_tag));
      s2_eff[i] = s2_rdy_q[i] | (bus.wakeup_valid && (s2_tag_q[i] == bus.wakeup_tag));
`else
      s1_eff[i] = s1_rdy_q[i];
      s2_eff[i] = s2_rdy_q[i];
`endif
    end
    ready_c = valid_q & s1_eff & s2_eff;
  end

  // Lowest-index free slot, from registered valid bits only
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  // Handshake decode; a freshly allocated slot is invalid in its own cycle,
  // so a grant aimed at it never qualifies.
  always_comb begin
    alloc_ready_c = (count_q < CW'(N));
    do_alloc      = bus.alloc_valid && alloc_ready_c && free_found;
    grant_idx     = bus.granted[IW-1:0];
    do_issue      = !bus.granted[CW-1] && ready_c[grant_idx];
    alloc_s1_rdy  = bus.alloc_src1_rdy | (bus.wakeup_valid && (bus.alloc_src1 == bus.wakeup_tag));
    alloc_s2_rdy  = bus.alloc_src2_rdy | (bus.wakeup_valid && (bus.alloc_src2 == bus.wakeup_tag));
  end

  // Slot storage, wakeup, issue and occupancy count
  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q         <= '0;
      s1_rdy_q        <= '0;
      s2_rdy_q        <= '0;
      count_q         <= '0;
      issue_valid_q   <= 1'b0;
      issue_index_q   <= '0;
      issue_dest_q    <= '0;
      issue_payload_q <= '0;
    end else if (FLUSH) begin
      valid_q       <= '0;
      count_q       <= '0;
      issue_valid_q <= 1'b0;
    end else begin
      issue_valid_q <= do_issue;
      if (do_issue) begin
        issue_index_q   <= grant_idx;
        issue_dest_q    <= dest_q[grant_idx];
        issue_payload_q <= payload_q[grant_idx];
        valid_q[grant_idx] <= 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (bus.wakeup_valid && valid_q[i]) begin
          if (s1_tag_q[i] == bus.wakeup_tag) s1_rdy_q[i] <= 1'b1;
          if (s2_tag_q[i] == bus.wakeup_tag) s2_rdy_q[i] <= 1'b1;
        end
      end
      if (do_alloc) begin
        valid_q[free_idx]   <= 1'b1;
        s1_tag_q[free_idx]  <= bus.alloc_src1;
        s2_tag_q[free_idx]  <= bus.alloc_src2;
        s1_rdy_q[free_idx]  <= alloc_s1_rdy;
        s2_rdy_q[free_idx]  <= alloc_s2_rdy;
        dest_q[free_idx]    <= bus.alloc_dest;
        payload_q[free_idx] <= bus.alloc_payload;
      end
      count_q <= count_q + CW'(do_alloc) - CW'(do_issue);
    end
  end

  assign bus.ready         = ready_c;
  assign bus.alloc_ready   = alloc_ready_c;
  assign bus.count         = count_q;
  assign bus.issue_valid   = issue_valid_q;
  assign bus.issue_index   = issue_index_q;
  assign bus.issue_dest    = issue_dest_q;
  assign bus.issue_payload = issue_payload_q;
endmodule

// File: tb/tb_issue_queue16.sv
// Self-checking bench for issue_queue16: a per-cycle vector table plus
// hand-written sequences for wakeup timing, full queue, flush and reset.
module tb_issue_queue16;
  logic clk;
  logic rst;
  logic flush;
  int   n_tests;
  int   n_fail;

  issue_queue16_if bus ();

  issue_queue16 dut (
    .CLK   (clk),
    .RESET (rst),
    .FLUSH (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [5:0]  s1;
    logic        r1;
    logic [5:0]  s2;
    logic        r2;
    logic [5:0]  dest;
    logic [31:0] pl;
    logic        wv;
    logic [5:0]  wt;
    logic [4:0]  gr;
    logic [15:0] e_ready;
    logic        e_ar;
    logic [4:0]  e_cnt;
    logic        e_iv;
    logic [3:0]  e_idx;
    logic [5:0]  e_dest;
    logic [31:0] e_pl;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush              = 1'b0;
    bus.alloc_valid    = 1'b0;
    bus.alloc_src1     = '0;
    bus.alloc_src2     = '0;
    bus.alloc_src1_rdy = 1'b0;
    bus.alloc_src2_rdy = 1'b0;
    bus.alloc_dest     = '0;
    bus.alloc_payload  = '0;
    bus.wakeup_valid   = 1'b0;
    bus.wakeup_tag     = '0;
    bus.granted        = 5'd16;
  endtask

  task automatic set_alloc(input logic [5:0] s1, input logic r1, input logic [5:0] s2,
                           input logic r2, input logic [5:0] dest, input logic [31:0] pl);
    bus.alloc_valid    = 1'b1;
    bus.alloc_src1     = s1;
    bus.alloc_src1_rdy = r1;
    bus.alloc_src2     = s2;
    bus.alloc_src2_rdy = r2;
    bus.alloc_dest     = dest;
    bus.alloc_payload  = pl;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic exp_same;
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    idle();

    //              av s1    r1 s2    r2 dest  pl            wv wt    gr     ready     ar  cnt  iv idx  dest  pl
    vecs[0]  = '{1, 6'h01, 1, 6'h02, 1, 6'h05, 32'hDEADBEEF, 0, 6'h00, 5'd16, 16'h0001, 1, 5'd1, 0, 4'd0, 6'h00, 32'h0};
    vecs[1]  = '{0, 6'h00, 0, 6'h00, 0, 6'h00, 32'h0,        0, 6'h00, 5'd0,  16'h0000, 1, 5'd0, 1, 4'd0, 6'h05, 32'hDEADBEEF};
    vecs[2]  = '{0, 6'h00, 0, 6'h00, 0, 6'h00, 32'h0,        0, 6'h00, 5'd16, 16'h0000, 1, 5'd0, 0, 4'd0, 6'h05, 32'hDEADBEEF};
    vecs[3]  = '{1, 6'h12, 0, 6'h13, 1, 6'h11, 32'h11111111, 0, 6'h00, 5'd16, 16'h0000, 1, 5'd1, 0, 4'd0, 6'h05, 32'hDEADBEEF};
    vecs[4]  = '{1, 6'h20, 1, 6'h21, 1, 6'h22, 32'h22222222, 0, 6'h00, 5'd0,  16'h0002, 1, 5'd2, 0, 4'd0, 6'h05, 32'hDEADBEEF};
    vecs[5]  = '{0, 6'h00, 0, 6'h00, 0, 6'h00, 32'h0,        0, 6'h00, 5'd16, 16'h0002, 1, 5'd2, 0, 4'd0, 6'h05, 32'hDEADBEEF};
    vecs[6]  = '{0, 6'h00, 0, 6'h00, 0, 6'h00, 32'h0,        1, 6'h12, 5'd16, 16'h0003, 1, 5'd2, 0, 4'd0, 6'h05, 32'hDEADBEEF};
    vecs[7]  = '{1, 6'h30, 0, 6'h31, 0, 6'h33, 32'h33333333, 1, 6'h30, 5'd1,  16'h0001, 1, 5'd2, 1, 4'd1, 6'h22, 32'h22222222};
    vecs[8]  = '{0, 6'h00, 0, 6'h00, 0, 6'h00, 32'h0,        1, 6'h31, 5'd0,  16'h0004, 1, 5'd1, 1, 4'd0, 6'h11, 32'h11111111};
    vecs[9]  = '{1, 6'h01, 1, 6'h02, 1, 6'h3F, 32'hCAFEF00D, 0, 6'h00, 5'd2,  16'h0001, 1, 5'd1, 1, 4'd2, 6'h33, 32'h33333333};
    vecs[10] = '{0, 6'h00, 0, 6'h00, 0, 6'h00, 32'h0,        0, 6'h00, 5'd1,  16'h0001, 1, 5'd1, 0, 4'd2, 6'h33, 32'h33333333};
    vecs[11] = '{0, 6'h00, 0, 6'h00, 0, 6'h00, 32'h0,        0, 6'h00, 5'd0,  16'h0000, 1, 5'd0, 1, 4'd0, 6'h3F, 32'hCAFEF00D};

    // Reset state, including outputs while RESET is still held
    rst = 1'b1;
    tick();
    check("rst_ready",   32'(bus.ready), 32'h0);
    check("rst_aready",  32'(bus.alloc_ready), 32'h1);
    check("rst_count",   32'(bus.count), 32'h0);
    check("rst_ivalid",  32'(bus.issue_valid), 32'h0);
    check("rst_index",   32'(bus.issue_index), 32'h0);
    check("rst_dest",    32'(bus.issue_dest), 32'h0);
    check("rst_payload", bus.issue_payload, 32'h0);
    rst = 1'b0;

    // Per-cycle vector table
    for (int v = 0; v < 12; v++) begin
      idle();
      bus.alloc_valid    = vecs[v].av;
      bus.alloc_src1     = vecs[v].s1;
      bus.alloc_src1_rdy = vecs[v].r1;
      bus.alloc_src2     = vecs[v].s2;
      bus.alloc_src2_rdy = vecs[v].r2;
      bus.alloc_dest     = vecs[v].dest;
      bus.alloc_payload  = vecs[v].pl;
      bus.wakeup_valid   = vecs[v].wv;
      bus.wakeup_tag     = vecs[v].wt;
      bus.granted        = vecs[v].gr;
      tick();
      check($sformatf("v%0d_ready", v),   32'(bus.ready), 32'(vecs[v].e_ready));
      check($sformatf("v%0d_aready", v),  32'(bus.alloc_ready), 32'(vecs[v].e_ar));
      check($sformatf("v%0d_count", v),   32'(bus.count), 32'(vecs[v].e_cnt));
      check($sformatf("v%0d_ivalid", v),  32'(bus.issue_valid), 32'(vecs[v].e_iv));
      check($sformatf("v%0d_index", v),   32'(bus.issue_index), 32'(vecs[v].e_idx));
      check($sformatf("v%0d_dest", v),    32'(bus.issue_dest), 32'(vecs[v].e_dest));
      check($sformatf("v%0d_payload", v), bus.issue_payload, vecs[v].e_pl);
    end

    // Wakeup timing on slot 3
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_alloc(6'h01, 1'b1, 6'h02, 1'b1, 6'(i), 32'(i));
      tick();
    end
    set_alloc(6'h12, 1'b0, 6'h02, 1'b1, 6'h03, 32'h00000333);
    tick();
    idle();
    #1;
    check("wk_before", 32'(bus.ready), 32'h0007);
    bus.wakeup_valid = 1'b1;
    bus.wakeup_tag   = 6'h12;
    #1;
`ifdef IQ_FAST_WAKEUP_EN
    exp_same = 1'b1;
`else
    exp_same = 1'b0;
`endif
    check("wk_same_cycle", 32'(bus.ready[3]), 32'(exp_same));
    tick();
    idle();
    #1;
    check("wk_next_cycle", 32'(bus.ready), 32'h000F);

    // Fill to 16, drop the 17th, refill a freed slot
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_alloc(6'h01, 1'b1, 6'h02, 1'b1, 6'(i), 32'(i));
      tick();
    end
    idle();
    check("full_count",  32'(bus.count), 32'd16);
    check("full_aready", 32'(bus.alloc_ready), 32'h0);
    check("full_ready",  32'(bus.ready), 32'hFFFF);
    set_alloc(6'h01, 1'b1, 6'h02, 1'b1, 6'h3E, 32'h00000099);
    tick();
    idle();
    check("drop17_count", 32'(bus.count), 32'd16);
    bus.granted = 5'd7;
    tick();
    idle();
    check("iss7_valid",   32'(bus.issue_valid), 32'h1);
    check("iss7_index",   32'(bus.issue_index), 32'd7);
    check("iss7_payload", bus.issue_payload, 32'd7);
    check("iss7_count",   32'(bus.count), 32'd15);
    check("iss7_ready",   32'(bus.ready), 32'hFF7F);
    check("iss7_aready",  32'(bus.alloc_ready), 32'h1);
    set_alloc(6'h01, 1'b1, 6'h02, 1'b1, 6'h2A, 32'h000000AA);
    tick();
    idle();
    check("refill_count", 32'(bus.count), 32'd16);
    check("refill_ready", 32'(bus.ready), 32'hFFFF);
    bus.granted = 5'd7;
    tick();
    idle();
    check("refill_index",   32'(bus.issue_index), 32'd7);
    check("refill_payload", bus.issue_payload, 32'h000000AA);
    check("refill_dest",    32'(bus.issue_dest), 32'h2A);
    set_alloc(6'h01, 1'b1, 6'h02, 1'b1, 6'h2B, 32'h000000BB);
    tick();
    idle();
    check("full2_count", 32'(bus.count), 32'd16);

    // Full queue: same-cycle alloc is dropped while slot 2 issues
    set_alloc(6'h01, 1'b1, 6'h02, 1'b1, 6'h2C, 32'h000000CC);
    bus.granted = 5'd2;
    tick();
    idle();
    check("fullai_valid",   32'(bus.issue_valid), 32'h1);
    check("fullai_index",   32'(bus.issue_index), 32'd2);
    check("fullai_payload", bus.issue_payload, 32'd2);
    check("fullai_count",   32'(bus.count), 32'd15);
    check("fullai_ready",   32'(bus.ready), 32'hFFFB);
    check("fullai_aready",  32'(bus.alloc_ready), 32'h1);

    // Flush overrides a simultaneous alloc and grant
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_alloc(6'h01, 1'b1, 6'h02, 1'b1, 6'(i), 32'(i));
      tick();
    end
    idle();
    check("pre_flush_count", 32'(bus.count), 32'd5);
    flush = 1'b1;
    set_alloc(6'h01, 1'b1, 6'h02, 1'b1, 6'h09, 32'h00000009);
    bus.granted = 5'd0;
    tick();
    idle();
    check("flush_count",  32'(bus.count), 32'd0);
    check("flush_ready",  32'(bus.ready), 32'h0);
    check("flush_ivalid", 32'(bus.issue_valid), 32'h0);
    check("flush_aready", 32'(bus.alloc_ready), 32'h1);

    // Reset mid-operation beats a pending grant
    for (int i = 0; i < 2; i++) begin
      set_alloc(6'h01, 1'b1, 6'h02, 1'b1, 6'h10, 32'h55550000 + 32'(i));
      tick();
    end
    idle();
    check("pre_mrst_ready", 32'(bus.ready), 32'h0003);
    rst = 1'b1;
    bus.granted = 5'd0;
    tick();
    check("mrst_ivalid",  32'(bus.issue_valid), 32'h0);
    check("mrst_count",   32'(bus.count), 32'd0);
    check("mrst_ready",   32'(bus.ready), 32'h0);
    check("mrst_payload", bus.issue_payload, 32'h0);
    rst = 1'b0;
    idle();
    tick();
    check("post_mrst_ivalid", 32'(bus.issue_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
